vec_alu_pipe: RTL
=================

Name: vec_alu_pipe

Overview:
- Parametrised, fully pipelined successor to the 64-bit SIMD vector ALU.
- Operates on a BITS-wide operand pair split into signed lanes of 8/16/32/64 bits, selected per transaction by precision.
- Adds a valid/ready handshake on both sides with backpressure, and signed saturating add/sub with a saturation flag.
- Sits between the vector register-read stage and writeback.

Parameters:
- BITS, 64, operand/result width; must be a multiple of 64.
- PRECISION, 2, width of precision field; lane width = 8 << precision (00=8, 01=16, 10=32, 11=64).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept beat this cycle
- a  input  BITS  first operand
- b  input  BITS  second operand
- opcode  input  4  operation select
- precision  input  PRECISION  lane width select
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- result_final  output  BITS  result vector
- carry  output  1  carry out of most-significant lane (add/sub/avg only, else 0)
- sat  output  1  any lane saturated (opcodes 1011/1100 only, else 0)
- op_err  output  1  opcode was unsupported (result zero)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at a clk edge, all stage registers clear: out_valid=0, result_final=0, carry=0, sat=0, op_err=0, s1_valid=0.
- Reset mid-operation drops all in-flight beats; nothing is replayed.
- Pipeline stage 1 (S1): registers a, b, opcode, precision and s1_valid on in_valid && in_ready.
- Pipeline stage 2 (S2/output): computes from the S1 registers and registers result_final, carry, sat, op_err and out_valid.
- Latency: exactly 2 cycles from the accepting edge to out_valid with no stall. Throughput is 1 beat per cycle.
- Output handshake: the output advances when !out_valid || out_ready. Otherwise all output regs hold stable (value and flags) until accepted.
- in_ready = !s1_valid || !out_valid || out_ready, i.e. S1 may refill while the output drains in the same cycle.
- With out_ready held low, the block holds 2 beats, and in_ready drops after the 2nd accept.
- in_valid is ignored when in_ready=0. a/b/opcode/precision are don't-care when in_valid=0.
- Lanes: lane width L = 8<<precision; BITS/L lanes, each fully independent. There is no carry across lane boundaries.
- All arithmetic is signed two's complement within the lane.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR.
  - 0011 ADD and 0110 SUB, both modulo 2^L.
  - 0100 SEQ and 0101 SNE: lane bit 0 = (a==b) or (a!=b); other lane bits 0.
  - 0111 AVGADD = floor((a+b)/2) and 1000 AVGSUB = floor((a-b)/2), using an (L+1)-bit intermediate, so the result never overflows.
  - 1001 MAX and 1010 MIN, signed compare; on tie, output a.
  - 1011 SADD and 1100 SSUB: saturate to +2^(L-1)-1 / -2^(L-1).
  - 1101–1111: result 0, op_err=1.
- carry: unsigned carry-out of the most-significant lane's adder. For SUB and AVGSUB the adder computes a+~b+1, so carry=1 means no borrow.
- sat: OR over lanes of the saturation event. It is 0 for all non-saturating opcodes.

Test Plan:
- rst high for 2 cycles mid-stream with 2 beats in flight -> out_valid=0 and all outputs 0 the cycle after; first new beat appears exactly 2 cycles after its accept.
- precision=00, SADD, a=0x7F..7F, b=0x01..01 -> result 0x7F7F7F7F7F7F7F7F, sat=1; ADD on the same operands -> 0x8080808080808080, sat=0, carry=0.
- precision=01, SSUB, lane a=0x8000, b=0x0001 in every lane -> 0x8000 per lane, sat=1; AVGSUB a=0x0003, b=0x0006 -> 0xFFFE per lane (floor(-3/2)=-2).
- precision=11, MAX, a=0xFFFFFFFFFFFFFFFF (-1), b=0x1 -> 0x1; MIN -> 0xFFFFFFFFFFFFFFFF; SEQ with a==b -> 0x1.
- Backpressure: 5 back-to-back beats with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, output holds beat 1 unchanged, then all 5 beats are delivered in order with none lost or duplicated.
- opcode=1110 -> result_final=0, op_err=1, carry=0, sat=0; next beat with a valid opcode clears op_err.

Source files
------------

// File: rtl/vec_alu_pipe_if.sv
// Operand/result bus for vec_alu_pipe.
// The master side feeds operand beats and takes results. The slave side is the ALU.
interface vec_alu_pipe_if #(
    parameter int BITS      = 64,
    parameter int PRECISION = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BITS-1:0]      a;
    logic [BITS-1:0]      b;
    logic [3:0]           opcode;
    logic [PRECISION-1:0] precision;
    logic                 out_valid;
    logic                 out_ready;
    logic [BITS-1:0]      result_final;
    logic                 carry;
    logic                 sat;
    logic                 op_err;

    modport master (
        output in_valid, a, b, opcode, precision, out_ready,
        input  in_ready, out_valid, result_final, carry, sat, op_err
    );

    modport slave (
        input  in_valid, a, b, opcode, precision, out_ready,
        output in_ready, out_valid, result_final, carry, sat, op_err
    );
endinterface

// File: rtl/vec_alu_pipe.sv
// Two-stage pipelined SIMD ALU with signed lanes of 8/16/32/64 bits.
// S1 captures the operands. S2 computes the lane results and holds them until the consumer takes them.
module vec_alu_pipe #(
    parameter int BITS      = 64,
    parameter int PRECISION = 2
) (
    input logic           clk,
    input logic           rst,
    vec_alu_pipe_if.slave bus
);
    typedef struct packed {
        logic [63:0] val;
        logic        cy;
        logic        sat;
    } lane_t;

    // One lane of width w. The operands arrive right-aligned in 64 bits, and bits above w are ignored.
    // The 66-bit signed intermediates hold any w+1-bit sum or difference exactly.
    function automatic lane_t lane_calc(input logic [63:0] x, input logic [63:0] y,
                                        input logic [3:0] op, input logic [6:0] w);
        logic [65:0] mask, xu, yu, xs, ys, sum, dif, usum, udif, smax, smin, pick;
        logic [5:0]  msb;
        lane_t       r;
        msb  = 6'(w - 7'd1);
        mask = (66'd1 << w) - 66'd1;
        xu   = {2'b00, x} & mask;
        yu   = {2'b00, y} & mask;
        xs   = x[msb] ? (xu | ~mask) : xu;
        ys   = y[msb] ? (yu | ~mask) : yu;
        sum  = xs + ys;
        dif  = xs - ys;
        usum = xu + yu;
        udif = xu + (~yu & mask) + 66'd1;
        smax = mask >> 1;
        smin = ~smax;
        r    = '0;
        pick = '0;
        case (op)
            4'h0: pick = xu & yu;
            4'h1: pick = xu | yu;
            4'h2: pick = xu ^ yu;
            4'h3: begin pick = usum; r.cy = usum[w]; end
            4'h4: pick = {65'd0, xu == yu};
            4'h5: pick = {65'd0, xu != yu};
            4'h6: begin pick = udif; r.cy = udif[w]; end
            4'h7: begin pick = 66'($signed(sum) >>> 1); r.cy = usum[w]; end
            4'h8: begin pick = 66'($signed(dif) >>> 1); r.cy = udif[w]; end
            4'h9: pick = ($signed(xs) >= $signed(ys)) ? xu : yu;
            4'hA: pick = ($signed(xs) <= $signed(ys)) ? xu : yu;
            4'hB: begin
                if ($signed(sum) > $signed(smax)) begin pick = smax; r.sat = 1'b1; end
                else if ($signed(sum) < $signed(smin)) begin pick = smin; r.sat = 1'b1; end
                else pick = sum;
            end
            4'hC: begin
                if ($signed(dif) > $signed(smax)) begin pick = smax; r.sat = 1'b1; end
                else if ($signed(dif) < $signed(smin)) begin pick = smin; r.sat = 1'b1; end
                else pick = dif;
            end
            default: pick = '0;
        endcase
        r.val = 64'(pick & mask);
        return r;
    endfunction

    logic                 s1_valid;
    logic [BITS-1:0]      s1_a, s1_b;
    logic [3:0]           s1_op;
    logic [PRECISION-1:0] s1_prec;

    logic                 out_valid_q, carry_q, sat_q, op_err_q;
    logic [BITS-1:0]      result_q;
    logic                 out_adv;

    logic [BITS-1:0]      res_c;
    logic                 carry_c, sat_c, op_err_c;
    logic [6:0]           lane_w;
    int                   lane_n;
    lane_t                ln;

    // Handshake: a beat transfers on a clk edge where valid && ready are both high.
    // The output register advances when it is empty or is being taken. S1 can refill when it is
    // empty or is moving into the output register in the same cycle.
    assign out_adv      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || out_adv;

    assign bus.out_valid    = out_valid_q;
    assign bus.result_final = result_q;
    assign bus.carry        = carry_q;
    assign bus.sat          = sat_q;
    assign bus.op_err       = op_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_prec  <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a    <= bus.a;
                s1_b    <= bus.b;
                s1_op   <= bus.opcode;
                s1_prec <= bus.precision;
            end
        end
    end

    always_comb begin
        res_c    = '0;
        carry_c  = 1'b0;
        sat_c    = 1'b0;
        ln       = '0;
        lane_w   = 7'd8 << s1_prec;
        lane_n   = BITS / int'(lane_w);
        op_err_c = (s1_op >= 4'd13);
        for (int i = 0; i < BITS / 8; i++) begin
            if (i < lane_n) begin
                ln    = lane_calc(64'(s1_a >> (i * lane_w)), 64'(s1_b >> (i * lane_w)), s1_op, lane_w);
                res_c = res_c | (BITS'(ln.val) << (i * lane_w));
                sat_c = sat_c | ln.sat;
                // The carry flag reports only the most significant lane.
                if (i == lane_n - 1) carry_c = ln.cy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            sat_q       <= 1'b0;
            op_err_q    <= 1'b0;
        end else if (out_adv) begin
            out_valid_q <= s1_valid;
            result_q    <= s1_valid ? res_c : '0;
            carry_q     <= s1_valid & carry_c;
            sat_q       <= s1_valid & sat_c;
            op_err_q    <= s1_valid & op_err_c;
        end
    end
endmodule
